uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Parametrised UART transmit serializer: accepts a parallel word with a start strobe, then drives one complete asynchronous frame (start, data LSB-first, optional parity, stop) on a registered serial line at a fixed baud rate. It sits between the UART register/command logic and the TX pin. It replaces the fixed 2-bit line-select mux with an internal frame state machine, baud counter, bit counter and busy/done handshake.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9)
- CLKS_PER_BIT, 434, clk cycles per serial bit (>= 2; 434 = 50 MHz / 115200)
- STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- tx_start  input  1  request to send tx_data; sampled only in IDLE
- tx_data  input  DATA_WIDTH  word to transmit; captured on an accepted tx_start
- parity_odd  input  1  1 = odd parity, 0 = even; captured with tx_data; ignored without UART_PARITY_EN
- tx_out  output  1  serial line, registered; idle level 1
- tx_busy  output  1  1 from the cycle after acceptance until the frame ends
- tx_done  output  1  one-cycle pulse marking end of frame

## Operation
- States: IDLE, START, DATA, PARITY (present only with UART_PARITY_EN), STOP.
- IDLE: tx_out=1, tx_busy=0. If tx_start=1, capture tx_data and parity_odd into a shift register, clear baud and bit counters, go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_out = shift_reg[0]; after each CLKS_PER_BIT cycles shift right by one and increment the bit counter; after DATA_WIDTH bits go to PARITY (or to STOP without the macro).
- PARITY: tx_out = (XOR of captured data) XOR parity_odd for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE with tx_done pulsed.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary; width $clog2(CLKS_PER_BIT). Bit counter width $clog2(DATA_WIDTH+1).
- tx_start while tx_busy=1 is ignored; captured data is not disturbed by changes on tx_data or parity_odd after acceptance.
- Illegal parameter values (CLKS_PER_BIT<2, STOP_BITS not 1/2, DATA_WIDTH outside 5..9) raise an elaboration-time $error.

## Timing
- Reset values: tx_out=1, tx_busy=0, tx_done=0, state IDLE, counters 0.
- rst=1 mid-frame aborts the frame: the next cycle shows tx_out=1, tx_busy=0, tx_done=0 (no done pulse for an aborted frame).
- Acceptance latency: tx_start high in cycle N (IDLE) -> tx_out=0 and tx_busy=1 from cycle N+1.
- Frame length: (1 + DATA_WIDTH + P + STOP_BITS) * CLKS_PER_BIT cycles, P = 1 with UART_PARITY_EN else 0; counted from the first start-bit cycle to the last stop-bit cycle inclusive.
- Each bit holds tx_out stable for exactly CLKS_PER_BIT cycles; no glitches at bit boundaries because tx_out is a flop.
- tx_done=1 for exactly one cycle: the first IDLE cycle after the last stop-bit cycle. tx_busy=0 in that cycle.
- Back-to-back: tx_start high in the tx_done cycle is accepted; the next start bit begins the following cycle, so the gap between frames is 0 idle bits beyond the stop bits.

## Configuration
- UART_PARITY_EN defined: PARITY state compiled in; frame carries one parity bit after data; parity_odd selects odd/even.
- UART_PARITY_EN undefined: PARITY state and parity logic removed; frame goes DATA -> STOP; parity_odd unused.

## Test plan
- Reset: hold rst=1 for 3 cycles with tx_start=1 -> tx_out=1, tx_busy=0, tx_done=0 throughout and one cycle after release before any start.
- Basic frame (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1, macro on): tx_data=8'hA5, parity_odd=0 -> line 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles, 44 cycles total, tx_done one cycle after.
- Odd parity: same data, parity_odd=1 -> parity bit 1; macro off -> 10-bit frame, 40 cycles, no parity bit.
- Ignore while busy: pulse tx_start with tx_data=8'hFF during data bit 3 of an 8'h00 frame -> line remains 8'h00 frame, no second frame.
- Back-to-back with STOP_BITS=2: tx_start asserted in the tx_done cycle with 8'h3C -> stop held 8 cycles, start bit of 8'h3C begins the next cycle.
- Reset mid-frame: assert rst during data bit 5 -> next cycle tx_out=1, tx_busy=0, no tx_done; new tx_start afterwards sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer.
// Accepts a parallel word on tx_start and sends one asynchronous frame
// (start, data LSB-first, optional parity, stop) on a registered tx_out.
// Optional feature macro: UART_PARITY_EN (adds one parity bit after data).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, waiting for tx_start
// START   | start bit (line low) for CLKS_PER_BIT cycles
// DATA    | data bits LSB-first, one per CLKS_PER_BIT cycles
// PARITY  | parity bit (only with UART_PARITY_EN)
// STOP    | STOP_BITS stop bits (line high), then back to IDLE with tx_done

module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  parity_odd,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
        $error("uart_tx_serializer: DATA_WIDTH must be in 5..9");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_out_q, tx_out_d;
    logic                    tx_busy_q, tx_busy_d;
    logic                    tx_done_q, tx_done_d;
    logic                    baud_end;

`ifdef UART_PARITY_EN
    // Parity bit is fixed at acceptance so later input changes cannot leak in.
    logic                    par_q, par_d;
`else
    logic                    unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_done_d = 1'b0;
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
        baud_end  = (baud_q == BAUD_LAST);
`ifdef UART_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_PARITY_EN
                    par_d   = (^tx_data) ^ parity_odd;
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // bit_q is reused here to count stop bits.
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d     = '0;
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the flop shows the new
        // bit in the same cycle the state register changes.
        case (state_d)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_out_d = par_d;
`endif
            default:   tx_out_d = 1'b1;
        endcase
        tx_busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shift register and output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_out_q  <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_out_q  <= tx_out_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
